// File: rtl/flash_copy_dma.sv
// flash_copy_dma: bus-master DMA that copies words from the quad-SPI
// flash window into system memory. Each chunk of up to maxBurst words is
// read into a local buffer and then written out as a single burst.
// Ports:
//   clock, reset       : clock and synchronous active-high reset
//   ci*                : custom-instruction configure/poll interface
//                        (ciDataB[1:0] selects: 0 src, 1 dst, 2 count+start,
//                        3 status only)
//   requestTransaction : bus request; transactionGranted is the grant
//   *Out               : master-side bus signals (begin, end, address/data,
//                        burst size, byte enables, write data valid)
//   *In                : read data, data valid, end, bus error, write stall
module flash_copy_dma #(
  parameter logic [7:0]  customInstructionNr = 8'd0,
  parameter logic [31:0] flashBase           = 32'h04000000,
  parameter int          maxBurst            = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciDataA,
  input  logic [31:0] ciDataB,
  input  logic        ciStart,
  input  logic        ciCke,
  output logic        ciDone,
  output logic [31:0] ciResult,
  output logic        requestTransaction,
  input  logic        transactionGranted,
  output logic        beginTransactionOut,
  output logic        endTransactionOut,
  output logic        readNotWriteOut,
  output logic [3:0]  byteEnablesOut,
  output logic [7:0]  burstSizeOut,
  output logic [31:0] addressDataOut,
  output logic        dataValidOut,
  input  logic [31:0] addressDataIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  input  logic        busErrorIn,
  input  logic        busyIn
);

  localparam int IW = $clog2(maxBurst);
  localparam int PW = IW + 1;
  localparam logic [15:0] MAXB = 16'(maxBurst);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_BEGIN,
    RD_DATA,
    WR_REQ,
    WR_BEGIN,
    WR_DATA,
    WR_END
  } state_t;

  state_t      state_q;
  logic [23:0] src_q;
  logic [31:0] dst_q;
  logic [15:0] rem_q;
  logic        err_q;
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [31:0] mem_q [maxBurst];

  logic [PW-1:0] chunk;
  logic [PW-1:0] chunk_m1;
  logic [PW+1:0] chunk_b;
  logic [PW-1:0] rd_cnt;
  logic [1:0]    sel;
  logic          ci_fire;
  logic          busy;
  logic          is_begin;
  logic [31:0]   status;
  logic          unused_ci;

  assign chunk    = (rem_q > MAXB) ? MAXB[PW-1:0] : rem_q[PW-1:0];
  assign chunk_m1 = chunk - PW'(1);
  assign chunk_b  = {chunk, 2'b00};
  // Words received including one arriving with endTransactionIn.
  assign rd_cnt   = wptr_q + PW'(dataValidIn);

  assign sel     = ciDataB[1:0];
  assign ci_fire = !reset && (ciN == customInstructionNr)
                   && ciStart && ciCke;
  assign busy    = (state_q != IDLE);
  assign status  = {busy, err_q, 14'd0, rem_q};

  assign ciDone    = ci_fire;
  assign ciResult  = ci_fire ? status : 32'd0;
  assign unused_ci = ^ciDataB[31:2];

  // Bus outputs are a pure decode of the registered state.
  assign is_begin = (state_q == RD_BEGIN) || (state_q == WR_BEGIN);

  assign requestTransaction  = busy;
  assign beginTransactionOut = is_begin;
  assign readNotWriteOut     = (state_q == RD_BEGIN);
  assign byteEnablesOut      = is_begin ? 4'hF : 4'h0;
  assign burstSizeOut        = is_begin ? 8'(chunk_m1) : 8'd0;
  assign dataValidOut        = (state_q == WR_DATA);
  assign endTransactionOut   = (state_q == WR_END);

  always_comb begin
    addressDataOut = 32'd0;
    unique case (state_q)
      RD_BEGIN: addressDataOut = flashBase | {8'd0, src_q};
      WR_BEGIN: addressDataOut = dst_q;
      WR_DATA:  addressDataOut = mem_q[rptr_q[IW-1:0]];
      default:  addressDataOut = 32'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (state_q == RD_DATA && dataValidIn && wptr_q < chunk) begin
      mem_q[wptr_q[IW-1:0]] <= addressDataIn;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= 24'd0;
      dst_q   <= 32'd0;
      rem_q   <= 16'd0;
      err_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      if (ci_fire && !busy) begin
        unique case (sel)
          2'd0: src_q <= ciDataA[23:0] & 24'hFFFFFC;
          2'd1: dst_q <= ciDataA & 32'hFFFFFFFC;
          2'd2: begin
            if (ciDataA[15:0] != 16'd0) begin
              rem_q   <= ciDataA[15:0];
              err_q   <= 1'b0;
              state_q <= RD_REQ;
            end
          end
          default: ;
        endcase
      end
      if (busy && busErrorIn) begin
        err_q   <= 1'b1;
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: ;
          RD_REQ: begin
            if (transactionGranted) state_q <= RD_BEGIN;
          end
          RD_BEGIN: begin
            wptr_q  <= '0;
            state_q <= RD_DATA;
          end
          RD_DATA: begin
            // Count one past chunk so an over-long burst is detected.
            if (dataValidIn && wptr_q <= chunk) begin
              wptr_q <= wptr_q + PW'(1);
            end
            if (endTransactionIn) begin
              if (rd_cnt == chunk) begin
                state_q <= WR_REQ;
              end else begin
                err_q   <= 1'b1;
                state_q <= IDLE;
              end
            end
          end
          WR_REQ: begin
            if (transactionGranted) state_q <= WR_BEGIN;
          end
          WR_BEGIN: begin
            rptr_q  <= '0;
            state_q <= WR_DATA;
          end
          WR_DATA: begin
            if (!busyIn) begin
              rptr_q <= rptr_q + PW'(1);
              if (rptr_q == chunk_m1) state_q <= WR_END;
            end
          end
          WR_END: begin
            src_q <= src_q + 24'(chunk_b);
            dst_q <= dst_q + 32'(chunk_b);
            rem_q <= rem_q - 16'(chunk);
            state_q <= (rem_q == 16'(chunk)) ? IDLE : RD_REQ;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flash_copy_dma.sv
// tb_flash_copy_dma: self-checking bench for flash_copy_dma with a
// flash/SDRAM bus slave model and a scoreboard of expected write words.
module tb_flash_copy_dma;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  ciN;
  logic [31:0] ciDataA;
  logic [31:0] ciDataB;
  logic        ciStart;
  logic        ciCke;
  logic        ciDone;
  logic [31:0] ciResult;
  logic        requestTransaction;
  logic        transactionGranted;
  logic        beginTransactionOut;
  logic        endTransactionOut;
  logic        readNotWriteOut;
  logic [3:0]  byteEnablesOut;
  logic [7:0]  burstSizeOut;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic [31:0] addressDataIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic        busErrorIn;
  logic        busyIn;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  flash_copy_dma dut (
    .clock(clock),
    .reset(reset),
    .ciN(ciN),
    .ciDataA(ciDataA),
    .ciDataB(ciDataB),
    .ciStart(ciStart),
    .ciCke(ciCke),
    .ciDone(ciDone),
    .ciResult(ciResult),
    .requestTransaction(requestTransaction),
    .transactionGranted(transactionGranted),
    .beginTransactionOut(beginTransactionOut),
    .endTransactionOut(endTransactionOut),
    .readNotWriteOut(readNotWriteOut),
    .byteEnablesOut(byteEnablesOut),
    .burstSizeOut(burstSizeOut),
    .addressDataOut(addressDataOut),
    .dataValidOut(dataValidOut),
    .addressDataIn(addressDataIn),
    .dataValidIn(dataValidIn),
    .endTransactionIn(endTransactionIn),
    .busErrorIn(busErrorIn),
    .busyIn(busyIn)
  );

  task automatic clear_bus;
    transactionGranted = 1'b0;
    addressDataIn = 32'd0;
    dataValidIn = 1'b0;
    endTransactionIn = 1'b0;
    busErrorIn = 1'b0;
    busyIn = 1'b0;
  endtask

  // Called just after a falling edge; returns there one cycle later.
  task automatic ci_op(input logic [7:0] n, input logic [1:0] sel,
                       input logic [31:0] val, output logic done,
                       output logic [31:0] res);
    ciN = n;
    ciDataA = val;
    ciDataB = {30'd0, sel};
    ciStart = 1'b1;
    ciCke = 1'b1;
    #1;
    done = ciDone;
    res = ciResult;
    @(negedge clock);
    ciStart = 1'b0;
    ciCke = 1'b0;
    ciDataA = 32'd0;
    ciDataB = 32'd0;
  endtask

  function automatic logic [63:0] all_outs();
    return {requestTransaction, beginTransactionOut, endTransactionOut,
            readNotWriteOut, byteEnablesOut, burstSizeOut,
            addressDataOut, dataValidOut, 15'd0};
  endfunction

  task automatic run_copy(input bit prog, input logic [23:0] src,
                          input logic [31:0] dst, input int cnt,
                          input int stall_word, input int stall_n,
                          input int err_chunk, input int rst_word);
    int rem, ci_idx, n, rd_idx, wr_idx, stall_left, cyc;
    bit rd_phase, done, aborted, rst_hit;
    logic d;
    logic [31:0] r, w, ea;
    logic [23:0] so;
    rem = cnt; ci_idx = 0; rd_idx = 0; wr_idx = 0;
    stall_left = stall_n; cyc = 0;
    rd_phase = 0; done = 0; aborted = 0; rst_hit = 0;
    if (prog) begin
      ci_op(8'd0, 2'd0, {8'd0, src}, d, r);
      ci_op(8'd0, 2'd1, dst, d, r);
    end
    ci_op(8'd0, 2'd2, 32'(cnt), d, r);
    while (!done && cyc < 3000) begin
      cyc++;
      n = (rem > 16) ? 16 : rem;
      clear_bus();
      transactionGranted = requestTransaction;
      if (beginTransactionOut) begin
        if (readNotWriteOut) begin
          so = src + 24'(64 * ci_idx);
          ea = 32'h04000000 | {8'd0, so};
          tests++;
          if (addressDataOut !== ea || burstSizeOut !== 8'(n - 1)
              || byteEnablesOut !== 4'hF) begin
            fails++;
            $display("FAIL rd_begin chunk %0d: addr %h bs %0d be %h, want addr %h bs %0d be f",
                     ci_idx, addressDataOut, burstSizeOut, byteEnablesOut, ea, n - 1);
          end
          rd_phase = 1; rd_idx = 0;
        end else begin
          ea = dst + 32'(64 * ci_idx);
          tests++;
          if (addressDataOut !== ea || burstSizeOut !== 8'(n - 1)
              || byteEnablesOut !== 4'hF) begin
            fails++;
            $display("FAIL wr_begin chunk %0d: addr %h bs %0d be %h, want addr %h bs %0d be f",
                     ci_idx, addressDataOut, burstSizeOut, byteEnablesOut, ea, n - 1);
          end
          ciN = 8'd0; ciDataB = 32'd3; ciStart = 1'b1; ciCke = 1'b1;
          #1;
          tests++;
          if (ciDone !== 1'b1 || ciResult !== {16'h8000, 16'(rem)}) begin
            fails++;
            $display("FAIL busy_poll chunk %0d: done %b status %h, want done 1 status %h",
                     ci_idx, ciDone, ciResult, {16'h8000, 16'(rem)});
          end
          ciStart = 1'b0; ciCke = 1'b0; ciDataB = 32'd0;
          wr_idx = 0;
        end
      end else if (rd_phase) begin
        if (ci_idx == err_chunk && rd_idx == 2) begin
          busErrorIn = 1'b1;
          rd_phase = 0; aborted = 1; done = 1;
        end else if (rd_idx < n) begin
          w = $urandom;
          dataValidIn = 1'b1;
          addressDataIn = w;
          exp_q.push_back(w);
          rd_idx++;
        end else begin
          endTransactionIn = 1'b1;
          rd_phase = 0;
        end
      end else if (dataValidOut) begin
        if (wr_idx == rst_word) begin
          reset = 1'b1;
          rst_hit = 1; done = 1;
        end else begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL wr_word %0d: got %h, want no more words", wr_idx, addressDataOut);
          end else if (addressDataOut !== exp_q[0]) begin
            fails++;
            $display("FAIL wr_word %0d: got %h, want %h", wr_idx, addressDataOut, exp_q[0]);
          end
          if (wr_idx == stall_word && stall_left > 0) begin
            busyIn = 1'b1;
            stall_left--;
          end else begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            wr_idx++;
          end
        end
      end else if (endTransactionOut) begin
        tests++;
        if (wr_idx != n || exp_q.size() != 0) begin
          fails++;
          $display("FAIL wr_end chunk %0d: words %0d left %0d, want words %0d left 0",
                   ci_idx, wr_idx, exp_q.size(), n);
        end
        rem -= n;
        ci_idx++;
        if (rem == 0) done = 1;
      end
      @(negedge clock);
    end
    clear_bus();
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL copy_timeout: cycles %0d, want completion", cyc);
    end
    exp_q.delete();
    if (rst_hit) begin
      tests++;
      if (all_outs() !== 64'd0 || ciDone !== 1'b0 || ciResult !== 32'd0) begin
        fails++;
        $display("FAIL reset_outs: %h done %b res %h, want 0", all_outs(), ciDone, ciResult);
      end
      reset = 1'b0;
      @(negedge clock);
      ci_op(8'd0, 2'd3, 32'd0, d, r);
      tests++;
      if (d !== 1'b1 || r !== 32'd0) begin
        fails++;
        $display("FAIL reset_status: done %b status %h, want 1 00000000", d, r);
      end
    end else begin
      tests++;
      if (requestTransaction !== 1'b0 || beginTransactionOut !== 1'b0
          || dataValidOut !== 1'b0) begin
        fails++;
        $display("FAIL idle_outs: req %b beg %b dv %b, want 0",
                 requestTransaction, beginTransactionOut, dataValidOut);
      end
      ea = aborted ? {16'h4000, 16'(rem)} : 32'd0;
      ci_op(8'd0, 2'd3, 32'd0, d, r);
      tests++;
      if (d !== 1'b1 || r !== ea) begin
        fails++;
        $display("FAIL end_status: done %b status %h, want 1 %h", d, r, ea);
      end
    end
  endtask

  task automatic test_reset;
    logic d;
    logic [31:0] r;
    reset = 1'b1;
    ciN = 8'd0; ciDataA = 32'd0; ciDataB = 32'd0;
    ciStart = 1'b0; ciCke = 1'b0;
    clear_bus();
    repeat (3) @(negedge clock);
    tests++;
    if (all_outs() !== 64'd0 || ciDone !== 1'b0 || ciResult !== 32'd0) begin
      fails++;
      $display("FAIL reset_outs: %h, want 0", all_outs());
    end
    reset = 1'b0;
    @(negedge clock);
    ci_op(8'd0, 2'd3, 32'd0, d, r);
    tests++;
    if (d !== 1'b1 || r !== 32'd0) begin
      fails++;
      $display("FAIL reset_status: done %b status %h, want 1 00000000", d, r);
    end
  endtask

  task automatic test_ci_ignore;
    logic d;
    logic [31:0] r;
    ci_op(8'd1, 2'd3, 32'd0, d, r);
    tests++;
    if (d !== 1'b0 || r !== 32'd0) begin
      fails++;
      $display("FAIL ci_other_nr: done %b res %h, want 0 00000000", d, r);
    end
    ci_op(8'd0, 2'd2, 32'd0, d, r);
    tests++;
    if (d !== 1'b1 || r !== 32'd0 || requestTransaction !== 1'b0) begin
      fails++;
      $display("FAIL start_count0: done %b res %h req %b, want 1 00000000 0",
               d, r, requestTransaction);
    end
  endtask

  task automatic test_busy_start;
    logic d;
    logic [31:0] r;
    ci_op(8'd0, 2'd0, 32'h00000300, d, r);
    ci_op(8'd0, 2'd1, 32'h00001000, d, r);
    ci_op(8'd0, 2'd2, 32'd3, d, r);
    ci_op(8'd0, 2'd0, 32'h00ABCDEC, d, r);
    ci_op(8'd0, 2'd1, 32'hFFFF0000, d, r);
    ci_op(8'd0, 2'd2, 32'd9, d, r);
    tests++;
    if (d !== 1'b1 || r !== 32'h80000003) begin
      fails++;
      $display("FAIL start_busy: done %b status %h, want 1 80000003", d, r);
    end
    busErrorIn = 1'b1;
    @(negedge clock);
    busErrorIn = 1'b0;
    ci_op(8'd0, 2'd3, 32'd0, d, r);
    tests++;
    if (r !== 32'h40000003 || requestTransaction !== 1'b0) begin
      fails++;
      $display("FAIL err_in_req: status %h req %b, want 40000003 0", r, requestTransaction);
    end
    run_copy(1'b0, 24'h000300, 32'h00001000, 2, -1, 0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_ci_ignore();
    run_copy(1'b1, 24'h000100, 32'h00800000, 5, -1, 0, -1, -1);
    run_copy(1'b1, 24'h000100, 32'h00800000, 40, -1, 0, -1, -1);
    run_copy(1'b1, 24'hFFFFF0, 32'hFFFFFFF0, 20, -1, 0, -1, -1);
    run_copy(1'b1, 24'h000040, 32'h00100000, 5, 2, 3, -1, -1);
    test_busy_start();
    run_copy(1'b1, 24'h000100, 32'h00800000, 40, -1, 0, 1, -1);
    run_copy(1'b1, 24'h000400, 32'h00200000, 8, -1, 0, -1, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/flash_copy_dma.md
Name: flash_copy_dma

Overview:
Bus-master DMA engine that copies a block of words from the quad-SPI flash window into system memory, e.g. SDRAM, for boot and overlay loading. It issues read bursts on the shared bus to the flash slave, buffers each burst in a 16-word local buffer, then issues a write burst to the destination. The CPU configures and polls it through a custom instruction.

Parameters:
customInstructionNr, 8'd0, custom-instruction number this block answers to
flashBase, 32'h04000000, base OR-ed onto the 24-bit source offset; bits [31:24] select the flash slave
maxBurst, 16, words per chunk; fixed buffer depth, power of two, at most 16

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
ciN  in  8  custom-instruction number
ciDataA  in  32  CI operand A (value)
ciDataB  in  32  CI operand B (selector)
ciStart  in  1  CI start
ciCke  in  1  CI clock enable
ciDone  out  1  CI done
ciResult  out  32  CI result; 0 when the CI is not addressed
requestTransaction  out  1  bus request to the arbiter
transactionGranted  in  1  arbiter grant
beginTransactionOut  out  1  one-cycle transaction start; address on addressDataOut
endTransactionOut  out  1  one-cycle end of a write burst
readNotWriteOut  out  1  1 = read; valid with beginTransactionOut
byteEnablesOut  out  4  always 4'hF when beginTransactionOut is high, else 0
burstSizeOut  out  8  words-1; valid with beginTransactionOut
addressDataOut  out  32  address or write data; 0 when not driving
dataValidOut  out  1  write data word valid
addressDataIn  in  32  read data
dataValidIn  in  1  read data word valid
endTransactionIn  in  1  slave/arbiter end of transaction
busErrorIn  in  1  bus error
busyIn  in  1  slave stall during a write burst

Behaviour:
- Reset: every output is 0. State goes to IDLE, the status error flag clears, and configuration registers clear to 0. A reset during an active transfer aborts immediately with no endTransactionOut; the arbiter relies on its own reset.
- CI fires when ciN==customInstructionNr & ciStart & ciCke. ciDone equals that condition in the same cycle. Selector is ciDataB[1:0]:
  - 0: srcOffset<=ciDataA[23:0] & ~3.
  - 1: dstAddr<=ciDataA & ~3.
  - 2: count<=ciDataA[15:0] and start. Start is ignored if state is not IDLE or count==0.
  - 3: read only.
  - Every selector returns the status word {busy, error, 14'd0, remaining[15:0]}.
- Writes to selectors 0/1 while busy are ignored.
- Chunk length = min(remaining, maxBurst).
- FSM: IDLE -> RD_REQ -> RD_BEGIN -> RD_DATA -> WR_REQ -> WR_BEGIN -> WR_DATA -> WR_END -> (RD_REQ if remaining>0, else IDLE).
  - RD_REQ / WR_REQ: assert requestTransaction; advance on transactionGranted.
  - requestTransaction stays high until the transaction's endTransactionIn (reads) or endTransactionOut (writes) has been seen.
  - RD_BEGIN: one cycle. beginTransactionOut=1, readNotWriteOut=1, addressDataOut=flashBase|srcOffset, burstSizeOut=chunk-1.
  - RD_DATA: each dataValidIn writes addressDataIn into buffer[wrPtr] and increments wrPtr. On endTransactionIn, exit: if wrPtr!=chunk, set error and go IDLE; otherwise go to WR_REQ.
  - WR_BEGIN: one cycle, readNotWriteOut=0, addressDataOut=dstAddr, burstSizeOut=chunk-1.
  - WR_DATA: drive buffer[rdPtr] with dataValidOut=1. rdPtr advances only on cycles with busyIn=0. After the last accepted word go to WR_END.
  - WR_END: one-cycle endTransactionOut. Then srcOffset+=4*chunk, dstAddr+=4*chunk, remaining-=chunk.
- busErrorIn in any non-IDLE state: set error, drop all bus outputs, go IDLE. Remaining keeps its value at the abort.
- srcOffset wraps modulo 2^24. dstAddr wraps modulo 2^32.
- busy=1 whenever state is not IDLE.
- error is sticky. It clears on the next accepted start.
- A CI status read in the same cycle as a state change returns the pre-edge (registered) values.

Test Plan:
- Copy count=5 from offset 0x000100 to 0x00800000 -> one read burst (address 0x04000100, burstSize 4), then one write burst to 0x00800000 with 5 words in order; status returns 0x00000000 afterwards.
- count=40 -> chunks of 16, 16, 8; read addresses +0x40 per chunk, write addresses likewise; busy=1 until the final endTransactionOut.
- Write burst with busyIn high for 3 cycles on word 2 -> word 2 held on addressDataOut for those cycles; no word duplicated or skipped.
- busErrorIn pulsed during RD_DATA of chunk 2 of count=40 -> IDLE next cycle, status = 0x40000018 (error=1, remaining=24).
- Start while busy, and start with count=0 -> both ignored; CI still returns ciDone=1 and the status word.
- Reset asserted mid WR_DATA -> next cycle all outputs 0 and status 0.
